// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - cell codes, direction encodings and sequencer states for the ball mover
package ball_pkg;

    localparam logic [7:0] CELL_FLOOR = 8'h00;
    localparam logic [7:0] CELL_WALL  = 8'h02;
    localparam logic [7:0] CELL_GOAL  = 8'h03;

    localparam logic [1:0] DIR_INC = 2'b10;
    localparam logic [1:0] DIR_DEC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_X_WAIT = 2'd1,
        ST_Y_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/ball_move_ctrl_if.sv
// rtl/ball_move_ctrl_if.sv - world-map read port between the ball sequencer and the map memory
interface ball_move_ctrl_if;
    logic [8:0] wrld_col_addr;
    logic [7:0] wrld_row_addr;
    logic [7:0] wrld_loc_info;

    modport master (output wrld_col_addr, output wrld_row_addr, input wrld_loc_info);
    modport slave  (input wrld_col_addr, input wrld_row_addr, output wrld_loc_info);
endinterface

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-axis candidate position with edge clamp (no arithmetic wrap)
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] pos,
    input  logic [1:0]   dir,
    input  logic [W-1:0] max,
    output logic [W-1:0] cand,
    output logic         at_edge,
    output logic         moving
);
    always_comb begin
        moving  = (dir == DIR_INC) || (dir == DIR_DEC);
        at_edge = ((dir == DIR_INC) && (pos == max)) ||
                  ((dir == DIR_DEC) && (pos == '0));
        cand    = pos;
        // Edge test precedes the +/-1 so the candidate never wraps
        if (moving && !at_edge) begin
            if (dir == DIR_INC) cand = pos + W'(1);
            else                cand = pos - W'(1);
        end
    end
endmodule

// File: rtl/ball_move_ctrl.sv
// rtl/ball_move_ctrl.sv - per-tick X then Y read/check/commit sequencer; GOAL_DETECT_EN adds sticky goal
module ball_move_ctrl
    import ball_pkg::*;
#(
    parameter int MAP_COLS    = 512,
    parameter int MAP_ROWS    = 256,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int MAP_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [1:0]        x_dir,
    input  logic [1:0]        y_dir,
    ball_move_ctrl_if.master  wrld,
    output logic [8:0]        ball_x,
    output logic [7:0]        ball_y,
    output logic              busy,
    output logic [1:0]        blocked,
    output logic              tick_miss,
    output logic              goal
);
    localparam int CNT_W = (MAP_LATENCY < 2) ? 1 : $clog2(MAP_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MAP_LATENCY);
    localparam logic [8:0] X_MAX = 9'(MAP_COLS - 1);
    localparam logic [7:0] Y_MAX = 8'(MAP_ROWS - 1);
`ifdef GOAL_DETECT_EN
    localparam bit GOAL_EN = 1'b1;
`else
    localparam bit GOAL_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       x_dir_q, x_dir_d, y_dir_q, y_dir_d, x_dir_sel;
    logic [8:0]       ball_x_d, col_d, cand_x;
    logic [7:0]       ball_y_d, row_d, cand_y;
    logic [1:0]       blocked_d;
    logic             miss_d, goal_d, x_edge, x_mov, y_edge, y_mov;

    // In IDLE the live direction forms the first address; afterwards the latched one
    assign x_dir_sel = (state_q == ST_IDLE) ? x_dir : x_dir_q;

    ball_axis_step #(.W(9)) u_step_x (
        .pos(ball_x), .dir(x_dir_sel), .max(X_MAX),
        .cand(cand_x), .at_edge(x_edge), .moving(x_mov)
    );

    ball_axis_step #(.W(8)) u_step_y (
        .pos(ball_y), .dir(y_dir_q), .max(Y_MAX),
        .cand(cand_y), .at_edge(y_edge), .moving(y_mov)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_dir_d   = x_dir_q;
        y_dir_d   = y_dir_q;
        ball_x_d  = ball_x;
        ball_y_d  = ball_y;
        col_d     = wrld.wrld_col_addr;
        row_d     = wrld.wrld_row_addr;
        blocked_d = 2'b00;
        miss_d    = 1'b0;
        goal_d    = goal;
        case (state_q)
            ST_IDLE: begin
                if (tick && !goal) begin
                    x_dir_d = x_dir;
                    y_dir_d = y_dir;
                    col_d   = cand_x;
                    row_d   = ball_y;
                    cnt_d   = LAT;
                    state_d = ST_X_WAIT;
                end
            end
            ST_X_WAIT: begin
                miss_d = tick && !goal;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (x_edge) begin
                        blocked_d[1] = 1'b1;
                    end else if (x_mov) begin
                        if (wrld.wrld_loc_info == CELL_WALL) begin
                            blocked_d[1] = 1'b1;
                        end else begin
                            ball_x_d = cand_x;
                            if (GOAL_EN && wrld.wrld_loc_info == CELL_GOAL) goal_d = 1'b1;
                        end
                    end
                    col_d   = ball_x_d;
                    row_d   = cand_y;
                    cnt_d   = LAT;
                    state_d = ST_Y_WAIT;
                end
            end
            ST_Y_WAIT: begin
                miss_d = tick && !goal;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // A goal reached on the X commit freezes the Y axis too
                    if (!goal) begin
                        if (y_edge) begin
                            blocked_d[0] = 1'b1;
                        end else if (y_mov) begin
                            if (wrld.wrld_loc_info == CELL_WALL) begin
                                blocked_d[0] = 1'b1;
                            end else begin
                                ball_y_d = cand_y;
                                if (GOAL_EN && wrld.wrld_loc_info == CELL_GOAL) goal_d = 1'b1;
                            end
                        end
                    end
                    row_d   = ball_y_d;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            cnt_q              <= '0;
            x_dir_q            <= 2'b00;
            y_dir_q            <= 2'b00;
            ball_x             <= 9'(START_X);
            ball_y             <= 8'(START_Y);
            wrld.wrld_col_addr <= 9'(START_X);
            wrld.wrld_row_addr <= 8'(START_Y);
            busy               <= 1'b0;
            blocked            <= 2'b00;
            tick_miss          <= 1'b0;
            goal               <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            x_dir_q            <= x_dir_d;
            y_dir_q            <= y_dir_d;
            ball_x             <= ball_x_d;
            ball_y             <= ball_y_d;
            wrld.wrld_col_addr <= col_d;
            wrld.wrld_row_addr <= row_d;
            busy               <= (state_d != ST_IDLE);
            blocked            <= blocked_d;
            tick_miss          <= miss_d;
            goal               <= goal_d;
        end
    end
endmodule

// File: tb/tb_ball_move_ctrl.sv
// tb/tb_ball_move_ctrl.sv - directed self-checking bench for ball_move_ctrl with a one-cycle map model
module tb_ball_move_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] x_dir = 2'b00;
    logic [1:0] y_dir = 2'b00;
    logic [8:0] ball_x;
    logic [7:0] ball_y;
    logic       busy, tick_miss, goal;
    logic [1:0] blocked;
    int         vectors = 0;
    int         miscompares = 0;

    logic       wall_en = 1'b0, goal_en = 1'b0;
    logic [8:0] wall_c = 9'd0, goal_c = 9'd0;
    logic [7:0] wall_r = 8'd0, goal_r = 8'd0;

    ball_move_ctrl_if wrld ();

    ball_move_ctrl #(
        .MAP_COLS(512), .MAP_ROWS(256), .START_X(1), .START_Y(1), .MAP_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .x_dir(x_dir), .y_dir(y_dir),
        .wrld(wrld), .ball_x(ball_x), .ball_y(ball_y), .busy(busy),
        .blocked(blocked), .tick_miss(tick_miss), .goal(goal)
    );

    always #5 clk = ~clk;

    // Registered map: data for an address appears one edge later
    always @(posedge clk) begin
        if (wall_en && wrld.wrld_col_addr == wall_c && wrld.wrld_row_addr == wall_r)
            wrld.wrld_loc_info <= 8'h02;
        else if (goal_en && wrld.wrld_col_addr == goal_c && wrld.wrld_row_addr == goal_r)
            wrld.wrld_loc_info <= 8'h03;
        else
            wrld.wrld_loc_info <= 8'h00;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic start_tick(input logic [1:0] xd, input logic [1:0] yd);
        @(negedge clk);
        tick = 1'b1; x_dir = xd; y_dir = yd;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (ball_x !== 9'd1) begin miscompares++; $display("FAIL rst_ball_x got=%0d exp=1", ball_x); end
        vectors++; if (ball_y !== 8'd1) begin miscompares++; $display("FAIL rst_ball_y got=%0d exp=1", ball_y); end
        vectors++; if ({busy, blocked, tick_miss, goal} !== 5'b0) begin miscompares++; $display("FAIL rst_flags got=%b exp=00000", {busy, blocked, tick_miss, goal}); end
        vectors++; if ({wrld.wrld_col_addr, wrld.wrld_row_addr} !== {9'd1, 8'd1}) begin miscompares++; $display("FAIL rst_addr got=(%0d,%0d) exp=(1,1)", wrld.wrld_col_addr, wrld.wrld_row_addr); end
    endtask

    task automatic test_floor_move();
        do_reset();
        start_tick(2'b10, 2'b01);
        x_dir = 2'b01; y_dir = 2'b10;
        vectors++; if (busy !== 1'b1 || wrld.wrld_col_addr !== 9'd2 || wrld.wrld_row_addr !== 8'd1) begin miscompares++; $display("FAIL fl_k busy=%b addr=(%0d,%0d) exp busy=1 addr=(2,1)", busy, wrld.wrld_col_addr, wrld.wrld_row_addr); end
        step();
        vectors++; if (ball_x !== 9'd1) begin miscompares++; $display("FAIL fl_k1_x got=%0d exp=1", ball_x); end
        step();
        vectors++; if (ball_x !== 9'd2 || blocked !== 2'b00) begin miscompares++; $display("FAIL fl_k2 x=%0d blocked=%b exp x=2 blocked=00", ball_x, blocked); end
        vectors++; if (wrld.wrld_col_addr !== 9'd2 || wrld.wrld_row_addr !== 8'd0) begin miscompares++; $display("FAIL fl_k2_addr got=(%0d,%0d) exp=(2,0)", wrld.wrld_col_addr, wrld.wrld_row_addr); end
        step();
        vectors++; if (busy !== 1'b1 || ball_y !== 8'd1) begin miscompares++; $display("FAIL fl_k3 busy=%b y=%0d exp busy=1 y=1", busy, ball_y); end
        step();
        vectors++; if (ball_y !== 8'd0 || busy !== 1'b0 || blocked !== 2'b00) begin miscompares++; $display("FAIL fl_k4 y=%0d busy=%b blocked=%b exp y=0 busy=0 blocked=00", ball_y, busy, blocked); end
    endtask

    task automatic test_wall();
        do_reset();
        wall_en = 1'b1; wall_c = 9'd2; wall_r = 8'd1;
        start_tick(2'b10, 2'b00);
        vectors++; if (wrld.wrld_col_addr !== 9'd2 || wrld.wrld_row_addr !== 8'd1) begin miscompares++; $display("FAIL wl_addr got=(%0d,%0d) exp=(2,1)", wrld.wrld_col_addr, wrld.wrld_row_addr); end
        step();
        step();
        vectors++; if (ball_x !== 9'd1 || blocked !== 2'b10) begin miscompares++; $display("FAIL wl_k2 x=%0d blocked=%b exp x=1 blocked=10", ball_x, blocked); end
        vectors++; if (wrld.wrld_col_addr !== 9'd1 || wrld.wrld_row_addr !== 8'd1) begin miscompares++; $display("FAIL wl_k2_addr got=(%0d,%0d) exp=(1,1)", wrld.wrld_col_addr, wrld.wrld_row_addr); end
        step();
        vectors++; if (blocked !== 2'b00) begin miscompares++; $display("FAIL wl_k3_pulse got=%b exp=00", blocked); end
        step();
        vectors++; if (ball_x !== 9'd1 || ball_y !== 8'd1 || blocked !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL wl_k4 pos=(%0d,%0d) blocked=%b busy=%b exp (1,1) 00 0", ball_x, ball_y, blocked, busy); end
        wall_en = 1'b0;
    endtask

    task automatic test_boundary();
        do_reset();
        start_tick(2'b01, 2'b10);
        wait_idle();
        for (int i = 0; i < 253; i++) begin
            start_tick(2'b00, 2'b10);
            wait_idle();
        end
        vectors++; if (ball_x !== 9'd0 || ball_y !== 8'd255) begin miscompares++; $display("FAIL bd_setup pos=(%0d,%0d) exp=(0,255)", ball_x, ball_y); end
        start_tick(2'b01, 2'b10);
        vectors++; if (wrld.wrld_col_addr !== 9'd0 || wrld.wrld_row_addr !== 8'd255) begin miscompares++; $display("FAIL bd_addr got=(%0d,%0d) exp=(0,255)", wrld.wrld_col_addr, wrld.wrld_row_addr); end
        step();
        step();
        vectors++; if (blocked !== 2'b10 || ball_x !== 9'd0) begin miscompares++; $display("FAIL bd_k2 blocked=%b x=%0d exp 10 0", blocked, ball_x); end
        step();
        vectors++; if (blocked !== 2'b00) begin miscompares++; $display("FAIL bd_k3 blocked=%b exp=00", blocked); end
        step();
        vectors++; if (blocked !== 2'b01 || ball_y !== 8'd255 || ball_x !== 9'd0) begin miscompares++; $display("FAIL bd_k4 blocked=%b pos=(%0d,%0d) exp 01 (0,255)", blocked, ball_x, ball_y); end
        step();
        vectors++; if (blocked !== 2'b00) begin miscompares++; $display("FAIL bd_k5 blocked=%b exp=00", blocked); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_tick(2'b10, 2'b00);
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        vectors++; if (tick_miss !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL bb_miss tick_miss=%b busy=%b exp 1 1", tick_miss, busy); end
        step();
        vectors++; if (tick_miss !== 1'b0 || busy !== 1'b0 || ball_x !== 9'd2) begin miscompares++; $display("FAIL bb_k4 tick_miss=%b busy=%b x=%0d exp 0 0 2", tick_miss, busy, ball_x); end
        tick = 1'b1; x_dir = 2'b10; y_dir = 2'b00;
        step();
        tick = 1'b0;
        vectors++; if (busy !== 1'b1 || tick_miss !== 1'b0 || wrld.wrld_col_addr !== 9'd3) begin miscompares++; $display("FAIL bb_accept busy=%b miss=%b col=%0d exp 1 0 3", busy, tick_miss, wrld.wrld_col_addr); end
        wait_idle();
        vectors++; if (ball_x !== 9'd3) begin miscompares++; $display("FAIL bb_second_x got=%0d exp=3", ball_x); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_tick(2'b10, 2'b10);
        step();
        step();
        step();
        #2 reset = 1'b0;
        #1;
        vectors++; if (ball_x !== 9'd1 || ball_y !== 8'd1 || busy !== 1'b0 || blocked !== 2'b00) begin miscompares++; $display("FAIL rm_async pos=(%0d,%0d) busy=%b blocked=%b exp (1,1) 0 00", ball_x, ball_y, busy, blocked); end
        vectors++; if (wrld.wrld_col_addr !== 9'd1 || wrld.wrld_row_addr !== 8'd1) begin miscompares++; $display("FAIL rm_addr got=(%0d,%0d) exp=(1,1)", wrld.wrld_col_addr, wrld.wrld_row_addr); end
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        step();
        vectors++; if (ball_y !== 8'd1 || busy !== 1'b0) begin miscompares++; $display("FAIL rm_after y=%0d busy=%b exp 1 0", ball_y, busy); end
    endtask

    task automatic test_goal();
        do_reset();
        goal_en = 1'b1; goal_c = 9'd2; goal_r = 8'd1;
        start_tick(2'b10, 2'b00);
        step();
        step();
`ifdef GOAL_DETECT_EN
        vectors++; if (ball_x !== 9'd2 || goal !== 1'b1) begin miscompares++; $display("FAIL gl_set x=%0d goal=%b exp 2 1", ball_x, goal); end
        wait_idle();
        start_tick(2'b10, 2'b10);
        vectors++; if (busy !== 1'b0 || tick_miss !== 1'b0) begin miscompares++; $display("FAIL gl_ignore busy=%b miss=%b exp 0 0", busy, tick_miss); end
        step();
        step();
        step();
        vectors++; if (ball_x !== 9'd2 || ball_y !== 8'd1 || goal !== 1'b1) begin miscompares++; $display("FAIL gl_frozen pos=(%0d,%0d) goal=%b exp (2,1) 1", ball_x, ball_y, goal); end
`else
        vectors++; if (ball_x !== 9'd2 || goal !== 1'b0) begin miscompares++; $display("FAIL gl_floor x=%0d goal=%b exp 2 0", ball_x, goal); end
        wait_idle();
        start_tick(2'b10, 2'b00);
        wait_idle();
        vectors++; if (ball_x !== 9'd3 || goal !== 1'b0) begin miscompares++; $display("FAIL gl_leave x=%0d goal=%b exp 3 0", ball_x, goal); end
`endif
        goal_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_floor_move();
        test_wall();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_goal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
